// File: rtl/tcm_pkg.sv
// ----------------------------------------------------------------------------
// tcm_pkg
// Shared types and helpers for the timing_check_monitor block.
//   tcm_state_e  : reference-pulse tracking state (LOW, HOLD, HIGH)
//   VIOL_CNT_W   : width of the violation counter output
//   sat_inc()    : saturating add of a small amount (0..3) to a VIOL_CNT_W value
// ----------------------------------------------------------------------------
package tcm_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'd0,  // reference low, waiting for a posedge
    HOLD = 2'd1,  // reference high, inside the hold window
    HIGH = 2'd2   // reference high, hold window closed
  } tcm_state_e;

  localparam int VIOL_CNT_W = 16;

  // Adds amt to val and sticks at all-ones instead of wrapping.
  function automatic logic [VIOL_CNT_W-1:0] sat_inc(input logic [VIOL_CNT_W-1:0] val,
                                                    input logic [1:0]            amt);
    logic [VIOL_CNT_W:0] sum;
    sum = {1'b0, val} + {{(VIOL_CNT_W-1){1'b0}}, amt};
    return sum[VIOL_CNT_W] ? {VIOL_CNT_W{1'b1}} : sum[VIOL_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/timing_check_monitor_if.sv
// ----------------------------------------------------------------------------
// timing_check_monitor_if
// Groups the signals under check and the violation reporting outputs.
//   ref_i, data_i, cond_i  : signals under check and the check enable
//   setup/hold/width_viol_o: one-cycle violation pulses
//   notifier_o             : toggles once per tick carrying any violation
//   viol_count_o           : saturating violation count
// Modports:
//   master : stimulus side (drives ref/data/cond, observes results)
//   slave  : the monitor itself
// ----------------------------------------------------------------------------
interface timing_check_monitor_if;
  import tcm_pkg::*;

  logic                  ref_i;
  logic                  data_i;
  logic                  cond_i;
  logic                  setup_viol_o;
  logic                  hold_viol_o;
  logic                  width_viol_o;
  logic                  notifier_o;
  logic [VIOL_CNT_W-1:0] viol_count_o;

  modport master (
    output ref_i, data_i, cond_i,
    input  setup_viol_o, hold_viol_o, width_viol_o, notifier_o, viol_count_o
  );

  modport slave (
    input  ref_i, data_i, cond_i,
    output setup_viol_o, hold_viol_o, width_viol_o, notifier_o, viol_count_o
  );

endinterface

// File: rtl/tcm_edge_det.sv
// ----------------------------------------------------------------------------
// tcm_edge_det
// Registers an asynchronous-to-the-check signal once and flags its edges by
// comparing the new sample with the previous one.
// Ports:
//   clk    in  sampling clock
//   rst    in  synchronous active-high reset (both samples cleared to 0)
//   i_sig  in  signal to sample
//   o_rise out sample went 0 -> 1 on the last clock
//   o_fall out sample went 1 -> 0 on the last clock
//   o_any  out either edge
// ----------------------------------------------------------------------------
module tcm_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall,
  output logic o_any
);

  logic r_smp;
  logic r_prev;

  // NOTE: registers use non-blocking assignments so r_prev captures the old
  // r_smp, not the value written in the same clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_smp  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_smp  <= i_sig;
      r_prev <= r_smp;
    end
  end

  assign o_rise = r_smp & ~r_prev;
  assign o_fall = ~r_smp & r_prev;
  assign o_any  = r_smp ^ r_prev;

endmodule

// File: rtl/timing_check_monitor.sv
// ----------------------------------------------------------------------------
// timing_check_monitor
// Cycle-based setup/hold/width checker. Oversamples ref_i and data_i on clk,
// measures tick distances between their edges and pulses a flag for each
// violation; notifier_o toggles once per violating tick, as a $setup/$hold/
// $width notifier would.
// Latency: input change -> sample register -> registered flag (2 clk).
// Parameters:
//   SETUP_TICKS  min ticks from last data edge to ref posedge (0 disables)
//   HOLD_TICKS   hold window length after ref posedge (0 disables)
//   WIDTH_TICKS  min ticks ref stays high (0 disables)
//   CNT_W        tick counter width; all *_TICKS must be < 2**CNT_W
// Ports:
//   clk  in  sampling clock, all logic on posedge
//   rst  in  synchronous active-high reset
//   bus  timing_check_monitor_if.slave (ref/data/cond in, flags/count out)
// Configuration macro:
//   TCM_VIOL_COUNT_EN  when defined, viol_count_o is a saturating 16-bit
//                      violation counter; otherwise it is tied to zero.
// ----------------------------------------------------------------------------
module timing_check_monitor
  import tcm_pkg::*;
#(
  parameter int unsigned SETUP_TICKS = 4,
  parameter int unsigned HOLD_TICKS  = 2,
  parameter int unsigned WIDTH_TICKS = 10,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  timing_check_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] SETUP_LIM = CNT_W'(SETUP_TICKS);
  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] WIDTH_LIM = CNT_W'(WIDTH_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // With no hold window the posedge goes straight to HIGH.
  localparam tcm_state_e POST_RISE = (HOLD_TICKS > 0) ? HOLD : HIGH;

  logic w_ref_rise, w_ref_fall, w_ref_any;
  logic w_data_rise, w_data_fall, w_data_any;

  tcm_edge_det u_ref_det (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (bus.ref_i),
    .o_rise (w_ref_rise),
    .o_fall (w_ref_fall),
    .o_any  (w_ref_any)
  );

  tcm_edge_det u_data_det (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (bus.data_i),
    .o_rise (w_data_rise),
    .o_fall (w_data_fall),
    .o_any  (w_data_any)
  );

  // Only the ref direction and the data "any edge" matter to the checks.
  logic w_unused_edges;
  assign w_unused_edges = w_ref_any ^ w_data_rise ^ w_data_fall;

  tcm_state_e       r_state;
  logic [CNT_W-1:0] r_data_age;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_setup_viol;
  logic             r_hold_viol;
  logic             r_width_viol;
  logic             r_notifier;

  // Age of the last data edge as seen on this tick: 0 on the edge tick itself,
  // so a data edge coinciding with the ref posedge counts as a setup hit.
  logic [CNT_W-1:0] w_age_now;
  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned and a latch is inferred.
  always_comb begin
    w_age_now = r_data_age + CNT_ONE;
    if (&r_data_age) w_age_now = r_data_age;
    if (w_data_any)  w_age_now = '0;
  end

  logic [CNT_W-1:0] w_hi_next;
  assign w_hi_next = (&r_hi_cnt) ? r_hi_cnt : r_hi_cnt + CNT_ONE;

  logic w_setup, w_hold, w_width, w_any_viol;
  // Setup is judged only on the LOW->high transition; a data edge on that
  // same tick is never a hold hit because the state is still LOW.
  assign w_setup = (r_state == LOW)  && w_ref_rise && bus.cond_i && (w_age_now < SETUP_LIM);
  assign w_hold  = (r_state == HOLD) && w_data_any && bus.cond_i;
  // r_hi_cnt equals the number of ticks since the posedge on the negedge tick.
  assign w_width = (r_state != LOW)  && w_ref_fall && bus.cond_i && (r_hi_cnt < WIDTH_LIM);
  assign w_any_viol = w_setup | w_hold | w_width;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LOW;
      r_data_age   <= '1;
      r_hi_cnt     <= '0;
      r_hold_cnt   <= '0;
      r_setup_viol <= 1'b0;
      r_hold_viol  <= 1'b0;
      r_width_viol <= 1'b0;
      r_notifier   <= 1'b0;
    end else begin
      r_setup_viol <= w_setup;
      r_hold_viol  <= w_hold;
      r_width_viol <= w_width;
      r_notifier   <= r_notifier ^ w_any_viol;
      r_data_age   <= w_age_now;

      case (r_state)
        LOW: begin
          if (w_ref_rise) begin
            r_state    <= POST_RISE;
            r_hi_cnt   <= CNT_ONE;
            r_hold_cnt <= CNT_ONE;
          end
        end
        HOLD: begin
          r_hi_cnt <= w_hi_next;
          // A negedge aborts the hold window early.
          if (w_ref_fall) begin
            r_state <= LOW;
          end else if (r_hold_cnt == HOLD_LIM) begin
            r_state <= HIGH;
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_ONE;
          end
        end
        HIGH: begin
          r_hi_cnt <= w_hi_next;
          if (w_ref_fall) r_state <= LOW;
        end
        default: r_state <= LOW;
      endcase
    end
  end

  assign bus.setup_viol_o = r_setup_viol;
  assign bus.hold_viol_o  = r_hold_viol;
  assign bus.width_viol_o = r_width_viol;
  assign bus.notifier_o   = r_notifier;

`ifdef TCM_VIOL_COUNT_EN
  // Setup and width can never share a tick (LOW vs not LOW), so at most two
  // flags are added per tick.
  logic [1:0]            w_n_viol;
  logic [VIOL_CNT_W-1:0] r_viol_count;

  assign w_n_viol = 2'(w_setup) + 2'(w_hold) + 2'(w_width);

  always_ff @(posedge clk) begin
    if (rst) r_viol_count <= '0;
    else     r_viol_count <= sat_inc(r_viol_count, w_n_viol);
  end

  assign bus.viol_count_o = r_viol_count;
`else
  assign bus.viol_count_o = '0;
`endif

endmodule

// File: tb/tb_timing_check_monitor.sv
// ----------------------------------------------------------------------------
// tb_timing_check_monitor
// Self-checking bench: directed scenarios for the documented corner cases
// followed by randomized ref/data/cond/rst stimulus. A timestamp-based model
// derives the expected flags from edge tick distances.
// ----------------------------------------------------------------------------
module tb_timing_check_monitor;
  import tcm_pkg::*;

  localparam int SETUP   = 4;
  localparam int HOLD    = 2;
  localparam int WIDTH   = 10;
  localparam int CNT_W   = 8;
  localparam int AGE_MAX = (1 << CNT_W) - 1;
`ifdef TCM_VIOL_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  timing_check_monitor_if tcm_bus ();

  timing_check_monitor #(
    .SETUP_TICKS (SETUP),
    .HOLD_TICKS  (HOLD),
    .WIDTH_TICKS (WIDTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tcm_bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // Edge events are timestamped in ticks; the checks are plain distance
  // comparisons against the limits.
  bit m_ref_s, m_ref_p, m_dat_s, m_dat_p;
  int tick = 0;
  int last_d_tick = 0;
  bit have_d = 1'b0;
  int rise_tick = 0;
  bit win = 1'b0;
  bit e_setup = 1'b0, e_hold = 1'b0, e_width = 1'b0, e_not = 1'b0;
  int e_cnt = 0;

  always @(posedge clk) begin : ref_model
    bit rr, rf, de;
    int age, hi, n;
    rr = m_ref_s & ~m_ref_p;
    rf = ~m_ref_s & m_ref_p;
    de = m_dat_s ^ m_dat_p;
    if (rst) begin
      e_setup = 1'b0; e_hold = 1'b0; e_width = 1'b0; e_not = 1'b0;
      e_cnt = 0; have_d = 1'b0; win = 1'b0;
      m_ref_s = 1'b0; m_ref_p = 1'b0; m_dat_s = 1'b0; m_dat_p = 1'b0;
    end else begin
      if (de)           age = 0;
      else if (!have_d) age = AGE_MAX;
      else              age = (tick - last_d_tick > AGE_MAX) ? AGE_MAX : tick - last_d_tick;
      hi = (tick - rise_tick > AGE_MAX) ? AGE_MAX : tick - rise_tick;
      e_setup = rr && tcm_bus.cond_i && (age < SETUP);
      e_hold  = win && de && tcm_bus.cond_i && (tick - rise_tick <= HOLD);
      e_width = win && rf && tcm_bus.cond_i && (hi < WIDTH);
      n = int'(e_setup) + int'(e_hold) + int'(e_width);
      if (n != 0) e_not = ~e_not;
      e_cnt = (e_cnt + n > 65535) ? 65535 : e_cnt + n;
      if (de) begin last_d_tick = tick; have_d = 1'b1; end
      if (rr) begin win = 1'b1; rise_tick = tick; end
      if (rf) win = 1'b0;
      m_ref_p = m_ref_s; m_ref_s = tcm_bus.ref_i;
      m_dat_p = m_dat_s; m_dat_s = tcm_bus.data_i;
    end
    tick++;
  end

  // ---------------------------------------------------------------- checks
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int seen_setup = 0, seen_hold = 0, seen_width = 0;

  task automatic compare_model();
    check("setup_viol", 32'(tcm_bus.setup_viol_o), 32'(e_setup));
    check("hold_viol",  32'(tcm_bus.hold_viol_o),  32'(e_hold));
    check("width_viol", 32'(tcm_bus.width_viol_o), 32'(e_width));
    check("notifier",   32'(tcm_bus.notifier_o),   32'(e_not));
    check("viol_count", 32'(tcm_bus.viol_count_o), COUNT_EN ? 32'(e_cnt) : 32'd0);
    if (tcm_bus.setup_viol_o === 1'b1) seen_setup++;
    if (tcm_bus.hold_viol_o  === 1'b1) seen_hold++;
    if (tcm_bus.width_viol_o === 1'b1) seen_width++;
  endtask

  // Holds the given inputs for n clocks; outputs are compared on each negedge.
  task automatic drive(input logic r, input logic d, input logic c, input logic rs, input int n);
    repeat (n) begin
      tcm_bus.ref_i  = r;
      tcm_bus.data_i = d;
      tcm_bus.cond_i = c;
      rst            = rs;
      @(negedge clk);
      if (chk_en) compare_model();
    end
  endtask

  task automatic phase_begin();
    seen_setup = 0; seen_hold = 0; seen_width = 0;
  endtask

  // exp = {setup, hold, width}: which flags must have pulsed in this phase.
  task automatic phase_end(input string tag, input logic [2:0] exp);
    check(tag, 32'({seen_setup != 0, seen_hold != 0, seen_width != 0}), 32'(exp));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic r_v, d_v, c_v, rs_v;
    tcm_bus.ref_i  = 1'b0;
    tcm_bus.data_i = 1'b0;
    tcm_bus.cond_i = 1'b1;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_setup",    32'(tcm_bus.setup_viol_o), 32'd0);
    check("rst_hold",     32'(tcm_bus.hold_viol_o),  32'd0);
    check("rst_width",    32'(tcm_bus.width_viol_o), 32'd0);
    check("rst_notifier", 32'(tcm_bus.notifier_o),   32'd0);
    check("rst_count",    32'(tcm_bus.viol_count_o), 32'd0);
    chk_en = 1'b1;
    drive(0, 0, 1, 0, 6);

    // Data edge 5 ticks before the posedge: clean.
    phase_begin();
    drive(0, 1, 1, 0, 5); drive(1, 1, 1, 0, 12); drive(0, 1, 1, 0, 8);
    phase_end("t1_setup_ok", 3'b000);
    check("t1_notifier", 32'(tcm_bus.notifier_o), 32'd0);

    // Data edge 2 ticks before the posedge: setup violation.
    phase_begin();
    drive(0, 0, 1, 0, 2); drive(1, 0, 1, 0, 12); drive(0, 0, 1, 0, 8);
    phase_end("t2_setup_viol", 3'b100);
    check("t2_notifier", 32'(tcm_bus.notifier_o), 32'd1);
    check("t2_count",    32'(tcm_bus.viol_count_o), COUNT_EN ? 32'd1 : 32'd0);

    // Data edge 1 tick after the posedge: hold violation, then suppressed by cond_i.
    phase_begin();
    drive(1, 0, 1, 0, 1); drive(1, 1, 1, 0, 11); drive(0, 1, 1, 0, 8);
    phase_end("t3_hold_viol", 3'b010);
    phase_begin();
    drive(1, 1, 0, 0, 1); drive(1, 0, 0, 0, 11); drive(0, 0, 0, 0, 8);
    phase_end("t3_hold_cond0", 3'b000);

    // Ref high 6 ticks: width violation; 12 ticks: clean.
    phase_begin();
    drive(1, 0, 1, 0, 6); drive(0, 0, 1, 0, 8);
    phase_end("t4_width_viol", 3'b001);
    phase_begin();
    drive(1, 0, 1, 0, 12); drive(0, 0, 1, 0, 8);
    phase_end("t4_width_ok", 3'b000);

    // Fresh reset, then data and ref posedge on the same tick, ref high 3.
    drive(0, 0, 1, 1, 2); drive(0, 0, 1, 0, 4);
    phase_begin();
    drive(1, 1, 1, 0, 3); drive(0, 1, 1, 0, 8);
    phase_end("t5_setup_width", 3'b101);
    check("t5_count",    32'(tcm_bus.viol_count_o), COUNT_EN ? 32'd2 : 32'd0);
    check("t5_notifier", 32'(tcm_bus.notifier_o), 32'd0);

    // Reset one tick into HOLD, data edge right after: nothing flagged.
    phase_begin();
    drive(1, 1, 1, 0, 2); drive(0, 1, 1, 1, 1);
    check("t6_count_clr", 32'(tcm_bus.viol_count_o), 32'd0);
    check("t6_notifier",  32'(tcm_bus.notifier_o),   32'd0);
    drive(0, 0, 1, 0, 1); drive(0, 0, 1, 0, 8);
    phase_end("t6_rst_abort", 3'b000);

    // Randomized traffic; ref pulse lengths straddle WIDTH, data edges land
    // both inside and outside the setup/hold windows.
    r_v = 1'b0; d_v = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r_v = ~r_v;
      if ($urandom_range(0, 4) == 0) d_v = ~d_v;
      c_v  = ($urandom_range(0, 9) != 0);
      rs_v = ($urandom_range(0, 299) == 0);
      drive(r_v, d_v, c_v, rs_v, 1);
    end
    drive(0, d_v, 1, 0, 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
